// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the memory-access stage.
// Latency: n/a (wires only).
// Backpressure: none; the pipeline advances every falling edge.
// Ports: master = EX/MEM side (drives *_EXMEM, observes *_MEMWB / err_sticky);
//        slave  = mem_stage (consumes *_EXMEM, drives registered outputs).
interface mem_stage_if;
    logic        MemRW_EXMEM;
    logic        regWen_EXMEM;
    logic [1:0]  WBsel_EXMEM;
    logic [2:0]  funct3_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic [31:0] Alu_out_EXMEM;
    logic [31:0] rs2_EXMEM;
    logic [31:0] pc_EXMEM;
    logic [31:0] wb_data_MEMWB;
    logic [4:0]  rd_MEMWB;
    logic        regWen_MEMWB;
    logic        misalign_MEMWB;
    logic        err_sticky;

    modport master (
        output MemRW_EXMEM, regWen_EXMEM, WBsel_EXMEM, funct3_EXMEM,
               rd_EXMEM, Alu_out_EXMEM, rs2_EXMEM, pc_EXMEM,
        input  wb_data_MEMWB, rd_MEMWB, regWen_MEMWB, misalign_MEMWB, err_sticky
    );

    modport slave (
        input  MemRW_EXMEM, regWen_EXMEM, WBsel_EXMEM, funct3_EXMEM,
               rd_EXMEM, Alu_out_EXMEM, rs2_EXMEM, pc_EXMEM,
        output wb_data_MEMWB, rd_MEMWB, regWen_MEMWB, misalign_MEMWB, err_sticky
    );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: word data memory, sub-word load/store, WB mux, MEM/WB register.
// Latency: one falling edge from EX/MEM inputs to MEM/WB outputs; load read is combinational.
// Backpressure: none; a new instruction is accepted on every falling edge.
// Ports: clk (state on negedge), rst_n (async active-low), bus (mem_stage_if.slave).
module mem_stage #(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic          is_st, is_ld;
    logic          acc_byte, acc_half, acc_word;
    logic          mis;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_ext;
    logic [31:0]   ld_data;

    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwen_q, regwen_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    always_comb begin
        widx  = bus.Alu_out_EXMEM[AW+1:2];
        off   = bus.Alu_out_EXMEM[1:0];
        // A store wins over a simultaneous load.
        is_st = bus.MemRW_EXMEM;
        is_ld = !bus.MemRW_EXMEM && (bus.WBsel_EXMEM == 2'd0) && bus.regWen_EXMEM;

        // Stores only know SB/SH/SW (everything else is SW); loads decode
        // size from funct3[1:0] with funct3[2] selecting zero extension.
        if (is_st) begin
            acc_byte = (bus.funct3_EXMEM == 3'b000);
            acc_half = (bus.funct3_EXMEM == 3'b001);
        end else begin
            acc_byte = (bus.funct3_EXMEM[1:0] == 2'b00);
            acc_half = (bus.funct3_EXMEM[1:0] == 2'b01);
        end
        acc_word = !acc_byte && !acc_half;

        mis   = (is_st || is_ld) &&
                ((acc_half && off[0]) || (acc_word && (off != 2'd0)));
        wr_en = is_st && !mis;

        // Replicate the store data across lanes; byte enables pick the lanes.
        if (acc_byte) begin
            be   = 4'b0001 << off;
            wdat = {4{bus.rs2_EXMEM[7:0]}};
        end else if (acc_half) begin
            be   = 4'b0011 << off;
            wdat = {2{bus.rs2_EXMEM[15:0]}};
        end else begin
            be   = 4'b1111;
            wdat = bus.rs2_EXMEM;
        end

        rd_word  = mem_q[widx];
        byte_sel = rd_word[8*off +: 8];
        half_sel = rd_word[16*off[1] +: 16];
        case (bus.funct3_EXMEM)
            3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_ext = {24'd0, byte_sel};
            3'b101:  ld_ext = {16'd0, half_sel};
            default: ld_ext = rd_word;
        endcase
        ld_data = (is_ld && !mis) ? ld_ext : 32'd0;

        case (bus.WBsel_EXMEM)
            2'd0:    wb_data_d = ld_data;
            2'd1:    wb_data_d = bus.Alu_out_EXMEM;
            2'd2:    wb_data_d = bus.pc_EXMEM + 32'd4;
            default: wb_data_d = 32'd0;
        endcase
        rd_d     = bus.rd_EXMEM;
        regwen_d = bus.regWen_EXMEM && !(is_ld && mis);
        mis_d    = mis;
        err_d    = err_q || mis;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q <= 32'd0;
            rd_q      <= 5'd0;
            regwen_q  <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wb_data_q <= wb_data_d;
            rd_q      <= rd_d;
            regwen_q  <= regwen_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
        end
    end

    // Contents survive reset; reset only blocks writes, so a store that
    // coincides with reset assertion is dropped.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[widx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    assign bus.wb_data_MEMWB  = wb_data_q;
    assign bus.rd_MEMWB       = rd_q;
    assign bus.regWen_MEMWB   = regwen_q;
    assign bus.misalign_MEMWB = mis_q;
    assign bus.err_sticky     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed reference model plus directed vectors.
// Latency: outputs compared 1 time unit after every falling edge.
// Backpressure: none.
module tb_mem_stage;

    logic clk;
    logic rst_n;
    mem_stage_if bus();

    mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference memory as 4096 bytes (1024 words), addressed modulo its size.
    logic [7:0] mm [4096];
    bit         err_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: evaluated from the inputs present at each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int unsigned ea;
            int          sz;
            bit          st, ld, sgn, mis;
            longint      v;
            logic [31:0] e_wb, ldv;
            logic [4:0]  e_rd;
            logic        e_we, e_mis;

            ea  = bus.Alu_out_EXMEM;
            st  = bus.MemRW_EXMEM;
            ld  = !st && bus.WBsel_EXMEM == 2'd0 && bus.regWen_EXMEM;
            if (st) sz = (bus.funct3_EXMEM == 3'd0) ? 1 : (bus.funct3_EXMEM == 3'd1) ? 2 : 4;
            else    sz = (bus.funct3_EXMEM[1:0] == 2'd0) ? 1 : (bus.funct3_EXMEM[1:0] == 2'd1) ? 2 : 4;
            sgn = !bus.funct3_EXMEM[2] && sz < 4;
            mis = (st || ld) && (ea % sz != 0);

            v = 0;
            for (int i = 0; i < sz; i++) v = v | (longint'(mm[(ea + i) % 4096]) << (8 * i));
            if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            ldv = (ld && !mis) ? 32'(v) : 32'd0;

            case (bus.WBsel_EXMEM)
                2'd0:    e_wb = ldv;
                2'd1:    e_wb = bus.Alu_out_EXMEM;
                2'd2:    e_wb = bus.pc_EXMEM + 32'd4;
                default: e_wb = 32'd0;
            endcase
            e_rd  = bus.rd_EXMEM;
            e_we  = bus.regWen_EXMEM && !(ld && mis);
            e_mis = mis;

            if (!rst_n) begin
                e_wb = 0; e_rd = 0; e_we = 0; e_mis = 0; err_m = 0;
            end else begin
                err_m = err_m || mis;
                if (st && !mis)
                    for (int i = 0; i < sz; i++) mm[(ea + i) % 4096] = 8'(bus.rs2_EXMEM >> (8 * i));
            end

            #1;
            chk("m_wb",  bus.wb_data_MEMWB, e_wb);
            chk("m_rd",  32'(bus.rd_MEMWB), 32'(e_rd));
            chk("m_we",  32'(bus.regWen_MEMWB), 32'(e_we));
            chk("m_mis", 32'(bus.misalign_MEMWB), 32'(e_mis));
            chk("m_err", 32'(bus.err_sticky), 32'(err_m));
        end
    end

    task automatic drive(input logic mw, input logic we, input logic [1:0] ws, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
        bus.MemRW_EXMEM   = mw;
        bus.regWen_EXMEM  = we;
        bus.WBsel_EXMEM   = ws;
        bus.funct3_EXMEM  = f3;
        bus.rd_EXMEM      = rd;
        bus.Alu_out_EXMEM = a;
        bus.rs2_EXMEM     = d;
        bus.pc_EXMEM      = pc;
    endtask

    // Present one instruction for a full MEM cycle; returns 2 units after its falling edge.
    task automatic op(input logic mw, input logic we, input logic [1:0] ws, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] pc);
        @(posedge clk);
        drive(mw, we, ws, f3, rd, a, d, pc);
        @(negedge clk);
        #2;
    endtask

    task automatic sw(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, 2'd1, f3, 5'd0, a, d, 32'h100);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a);
        op(1'b0, 1'b1, 2'd0, f3, rd, a, 32'd0, 32'h200);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb"},  bus.wb_data_MEMWB, 32'd0);
        chk({tag, "_rd"},  32'(bus.rd_MEMWB), 32'd0);
        chk({tag, "_we"},  32'(bus.regWen_MEMWB), 32'd0);
        chk({tag, "_mis"}, 32'(bus.misalign_MEMWB), 32'd0);
        chk({tag, "_err"}, 32'(bus.err_sticky), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        @(posedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Word round trip
        sw(3'b010, 32'h10, 32'hDEADBEEF);
        ld(3'b010, 5'd5, 32'h10);
        chk("rt_wb", bus.wb_data_MEMWB, 32'hDEADBEEF);
        chk("rt_rd", 32'(bus.rd_MEMWB), 32'd5);
        chk("rt_we", 32'(bus.regWen_MEMWB), 32'd1);

        // Sub-word merge and extension
        sw(3'b010, 32'h20, 32'h11223344);
        sw(3'b000, 32'h21, 32'h00000080);
        ld(3'b000, 5'd1, 32'h21);
        chk("lb", bus.wb_data_MEMWB, 32'hFFFFFF80);
        ld(3'b100, 5'd1, 32'h21);
        chk("lbu", bus.wb_data_MEMWB, 32'h00000080);
        ld(3'b001, 5'd1, 32'h22);
        chk("lh", bus.wb_data_MEMWB, 32'h00001122);
        ld(3'b010, 5'd1, 32'h20);
        chk("lw_merged", bus.wb_data_MEMWB, 32'h11228044);
        sw(3'b001, 32'h22, 32'h0000BEEF);
        ld(3'b001, 5'd2, 32'h22);
        chk("lh_neg", bus.wb_data_MEMWB, 32'hFFFFBEEF);
        ld(3'b101, 5'd2, 32'h22);
        chk("lhu", bus.wb_data_MEMWB, 32'h0000BEEF);

        // Misalignment
        sw(3'b010, 32'h30, 32'h12345678);
        chk("pre_err", 32'(bus.err_sticky), 32'd0);
        sw(3'b010, 32'h31, 32'hAAAA5555);
        chk("mis_sw", 32'(bus.misalign_MEMWB), 32'd1);
        chk("mis_sw_err", 32'(bus.err_sticky), 32'd1);
        ld(3'b010, 5'd6, 32'h31);
        chk("mis_lw", 32'(bus.misalign_MEMWB), 32'd1);
        chk("mis_lw_we", 32'(bus.regWen_MEMWB), 32'd0);
        chk("mis_lw_wb", bus.wb_data_MEMWB, 32'd0);
        ld(3'b001, 5'd7, 32'h33);
        chk("mis_lh", 32'(bus.misalign_MEMWB), 32'd1);
        chk("mis_lh_we", 32'(bus.regWen_MEMWB), 32'd0);
        ld(3'b010, 5'd8, 32'h30);
        chk("mis_mem", bus.wb_data_MEMWB, 32'h12345678);
        chk("mis_drop", 32'(bus.misalign_MEMWB), 32'd0);
        chk("mis_sticky", 32'(bus.err_sticky), 32'd1);
        ld(3'b000, 5'd8, 32'h33);
        chk("lb_odd", bus.wb_data_MEMWB, 32'h00000012);

        // Write-back select
        op(1'b0, 1'b1, 2'd1, 3'd0, 5'd3, 32'h1234, 32'd0, 32'd0);
        chk("wbsel1", bus.wb_data_MEMWB, 32'h1234);
        op(1'b0, 1'b1, 2'd2, 3'd0, 5'd3, 32'h0, 32'd0, 32'hFFFFFFFC);
        chk("wbsel2", bus.wb_data_MEMWB, 32'h0);
        op(1'b0, 1'b1, 2'd1, 3'd0, 5'd3, 32'h55, 32'd0, 32'd0);
        op(1'b0, 1'b1, 2'd3, 3'd0, 5'd3, 32'h55, 32'd0, 32'h8);
        chk("wbsel3", bus.wb_data_MEMWB, 32'h0);

        // Address wrap
        sw(3'b010, 32'h1000, 32'h5A5A5A5A);
        ld(3'b010, 5'd4, 32'h0);
        chk("wrap", bus.wb_data_MEMWB, 32'h5A5A5A5A);

        // Reset mid-operation
        sw(3'b010, 32'h40, 32'h01020304);
        op(1'b0, 1'b1, 2'd1, 3'd0, 5'd3, 32'h777, 32'd0, 32'd0);
        chk("pre_rst_wb", bus.wb_data_MEMWB, 32'h777);
        @(posedge clk);
        drive(1'b1, 1'b0, 2'd1, 3'b010, 5'd9, 32'h40, 32'h0BADF00D, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge clk);
        drive(1'b0, 1'b0, 2'd1, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        ld(3'b010, 5'd9, 32'h40);
        chk("rst_drop", bus.wb_data_MEMWB, 32'h01020304);
        chk("rst_err", 32'(bus.err_sticky), 32'd0);

        @(posedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the EX/MEM pipeline register. It holds the word-organised data memory and performs byte, halfword and word loads and stores with sign or zero extension. It selects the write-back value and registers it, with the destination register and write enable, into the MEM/WB register that feeds the register file. It also detects misaligned accesses, suppresses them and flags them.

## Interface
- DEPTH, 1024: data memory size in 32-bit words; power of two, ≥ 4.
- AW, log2(DEPTH): word-address width; derived, not overridden.

- clk  in  1  pipeline clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRW_EXMEM  in  1  1 = store, 0 = no memory write.
- regWen_EXMEM  in  1  register write enable of the instruction in MEM.
- WBsel_EXMEM  in  2  write-back select: 0 = load data, 1 = ALU result, 2 = pc+4, 3 = reserved.
- funct3_EXMEM  in  3  RISC-V funct3 of the load/store.
- rd_EXMEM  in  5  destination register.
- Alu_out_EXMEM  in  32  effective address or ALU result.
- rs2_EXMEM  in  32  store data.
- pc_EXMEM  in  32  PC of the instruction in MEM.
- wb_data_MEMWB  out  32  registered write-back value.
- rd_MEMWB  out  5  registered destination register.
- regWen_MEMWB  out  1  registered register write enable.
- misalign_MEMWB  out  1  registered one-cycle flag: the instruction now in WB was a misaligned access.
- err_sticky  out  1  set by any misaligned access; cleared only by reset.

## Operation
- Load: WBsel_EXMEM = 0 and regWen_EXMEM = 1.
- Store: MemRW_EXMEM = 1.
- Word index = Alu_out_EXMEM[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo DEPTH words.
- Lane offset = Alu_out_EXMEM[1:0].
- Stores:
  - funct3 000 (SB): write rs2[7:0] to byte lane `off`.
  - funct3 001 (SH): write rs2[15:0] to lanes off and off+1.
  - funct3 010 (SW): write the full word.
  - Other funct3 values: treated as SW.
  - Unwritten lanes are preserved.
- Loads: the word is read combinationally.
  - 000 LB: sign-extend byte lane `off`.
  - 001 LH: sign-extend the halfword at lanes off..off+1.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte lane `off`.
  - 101 LHU: zero-extend the halfword at lanes off..off+1.
  - 011, 110, 111: treated as LW.
- Misaligned access:
  - Halfword access (funct3[1:0] = 01) with off[0] = 1.
  - Word access (funct3[1:0] = 10, or the treated-as-word codes) with off ≠ 0.
  - Byte access is never misaligned.
- Misaligned store: memory unchanged.
- Misaligned load: load data = 0 and regWen_MEMWB forced to 0.
- Either misaligned case: misalign_MEMWB = 1 for that instruction, and err_sticky sets.
- An access that is both load and store is treated as a store only. Load data is ignored; WBsel still applies.
- Write-back mux:
  - WBsel 0: extended load data.
  - WBsel 1: Alu_out_EXMEM.
  - WBsel 2: pc_EXMEM + 4 (32-bit, wraps at 2^32).
  - WBsel 3: 0.
- Memory contents are not cleared by reset.

## Timing
- All registers and the memory write port act on the falling edge of clk, the same edge as the other pipeline registers.
- Memory read is combinational from Alu_out_EXMEM. Load data appears on wb_data_MEMWB at the falling edge that ends the instruction's MEM cycle (one-edge latency, same as non-load results).
- A store followed by a load to the same word in the next cycle returns the new data: the write lands on the edge, and the next read sees it.
- Reset (asynchronous, any time) forces:
  - wb_data_MEMWB = 0, rd_MEMWB = 0, regWen_MEMWB = 0, misalign_MEMWB = 0, err_sticky = 0.
- While rst_n = 0, no memory writes occur. A store coinciding with reset assertion is dropped.
- First falling edge after rst_n rises: normal capture.
- misalign_MEMWB is registered per instruction. It stays 1 across consecutive misaligned instructions and drops on the first aligned one.

## Test plan
- Word round trip:
  - Stimulus: SW 0xDEADBEEF to 0x10, then next cycle LW 0x10, WBsel 0, rd 5.
  - Required: wb_data_MEMWB = 0xDEADBEEF, rd_MEMWB = 5, regWen_MEMWB = 1 one edge later.
- Sub-word merge and extension:
  - Stimulus: SW 0x11223344 to 0x20, then SB 0x80 to 0x21, then LB 0x21, then LBU 0x21, then LH 0x22.
  - Required: 0xFFFFFF80, then 0x00000080, then 0x00001122 (stored word now 0x11228044).
- Misalignment:
  - Stimulus: SW 0xAAAA5555 to 0x31, then LW 0x31, then LH 0x33.
  - Required: memory at 0x30 unchanged. Each instruction gives misalign_MEMWB = 1. Both loads give regWen_MEMWB = 0 and wb_data_MEMWB = 0. err_sticky = 1 until reset.
- Write-back select:
  - Stimulus: WBsel 1 with Alu_out 0x1234; WBsel 2 with pc 0xFFFFFFFC; WBsel 3.
  - Required: 0x1234, then 0x00000000 (wrap), then 0.
- Address wrap with DEPTH = 1024:
  - Stimulus: SW 0x5A5A5A5A to 0x1000, then LW 0x0.
  - Required: 0x5A5A5A5A.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 between edges while SW 0x0BADF00D to 0x40 is presented and outputs are non-zero; release, then LW 0x40.
  - Required: all outputs 0 immediately on assertion, err_sticky = 0, and the load returns the prior contents of 0x40 (store dropped).
